axi_lite_dpic_sram_lat: RTL
===========================

// Module: axi_lite_dpic_sram_lat
// PURPOSE
// - AXI4-Lite slave simulation memory backed by the DPI-C pmem_read/pmem_write model.
// - Next-generation simulation SRAM with these additions:
//   - AW and W are accepted independently.
//   - Read and write latency are programmable.
//   - Out-of-range addresses return DECERR.
//   - Data width is 32 or 64 bits.
// - Sits at the end of the core's AXI-Lite fabric in the playground testbench.
// PARAMETERS
// - ADDR_WIDTH  32          address width
// - DATA_WIDTH  32          32 or 64; 64 splits into two 32-bit DPI calls (low lane at addr, high lane at addr+4)
// - RD_LATENCY  1           cycles from AR handshake to r_valid; legal range 1..15
// - WR_LATENCY  1           cycles from holding both AW and W to b_valid; legal range 1..15
// - BASE_ADDR   32'h8000_0000  first mapped byte
// - MEM_BYTES   32'h0800_0000  mapped size; in range iff BASE_ADDR <= addr < BASE_ADDR+MEM_BYTES
// PORTS
// - clock           in   1           rising-edge clock
// - reset           in   1           asynchronous, active-low reset
// - ioAXI_aw_valid  in   1           write address valid
// - ioAXI_aw_ready  out  1           write address ready
// - ioAXI_aw_addr   in   ADDR_WIDTH  write address
// - ioAXI_aw_prot   in   3           ignored
// - ioAXI_w_valid   in   1           write data valid
// - ioAXI_w_ready   out  1           write data ready
// - ioAXI_w_data    in   DATA_WIDTH  write data
// - ioAXI_w_strb    in   DATA_WIDTH/8  byte strobes
// - ioAXI_b_valid   out  1           write response valid
// - ioAXI_b_ready   in   1           write response ready
// - ioAXI_b_resp    out  2           2'b00 OKAY / 2'b11 DECERR
// - ioAXI_ar_valid  in   1           read address valid
// - ioAXI_ar_ready  out  1           read address ready
// - ioAXI_ar_addr   in   ADDR_WIDTH  read address
// - ioAXI_ar_prot   in   3           ignored
// - ioAXI_r_valid   out  1           read data valid
// - ioAXI_r_ready   in   1           read data ready
// - ioAXI_r_data    out  DATA_WIDTH  read data
// - ioAXI_r_resp    out  2           2'b00 OKAY / 2'b11 DECERR
// BEHAVIOUR
// - Reset (reset==0, async):
//   - All ready/valid outputs, resp, r_data, counters and captured addr/data/strb go to 0.
//   - Both FSMs go to IDLE. An in-flight transaction is dropped; no DPI call is made for it.
// - All outputs are registered. Readies assert on the first rising edge after reset deasserts.
// - Write FSM, states W_IDLE -> W_WAIT -> W_RESP -> W_IDLE:
//   - W_IDLE:
//     - aw_ready=1 until AW is captured; w_ready=1 until W is captured. Each ready drops the cycle after its own handshake.
//     - AW and W may arrive in either order or in the same cycle.
//     - Once both are held, enter W_WAIT with cnt=WR_LATENCY-1.
//   - W_WAIT:
//     - Decrement cnt each cycle.
//     - On the edge where cnt==0: call pmem_write (clocked, exactly once) if in range; set b_valid=1 and b_resp; enter W_RESP.
//   - W_RESP: hold b_valid/b_resp until b_ready; on the handshake clear b_valid and return to W_IDLE, where readies re-assert.
// - Read FSM, states R_IDLE -> R_WAIT -> R_RESP -> R_IDLE:
//   - R_IDLE: ar_ready=1. On the handshake, capture the address, drop ar_ready and enter R_WAIT with cnt=RD_LATENCY-1.
//   - R_WAIT:
//     - Decrement cnt each cycle.
//     - On the edge where cnt==0: call pmem_read into r_data, or load 0 with DECERR if out of range; set r_valid=1; enter R_RESP.
//     - With RD_LATENCY=1, r_valid is high the cycle after the AR handshake.
//   - R_RESP: r_data/r_resp stay stable while r_valid && !r_ready. On the handshake clear r_valid and return to R_IDLE.
// - Address and strobes:
//   - Addresses are aligned down to DATA_WIDTH/8.
//   - A 64-bit write with a zero strobe half skips that lane's DPI call; an all-zero strobe makes no DPI call at all.
//   - A write with an all-zero strobe still returns OKAY.
// - Read and write FSMs run concurrently. If a write commit and a read sample hit the same address on the same edge,
//   the write is issued first and the read returns the new data.
// - Range check uses the full ADDR_WIDTH. No wrap: an address >= BASE_ADDR+MEM_BYTES gives DECERR.
// CONFIGURATION
// - AXI_SRAM_RAND_DELAY_EN defined:
//   - A 16-bit LFSR (seed 16'hACE1, reset to seed) adds 0..7 extra wait cycles, taken from lfsr[2:0].
//   - The extra cycles are loaded on entry to W_WAIT and R_WAIT.
//   - The LFSR steps every cycle.
// - AXI_SRAM_RAND_DELAY_EN undefined: latency is exactly RD_LATENCY / WR_LATENCY.
// TESTING
// 1. Write, then read:
//    - AW+W same cycle, addr=32'h8000_0010, data=32'hDEAD_BEEF, strb=4'hF -> b_valid 1 cycle later, resp 00.
//    - AR to the same addr -> r_data=32'hDEAD_BEEF, resp 00.
// 2. W before AW:
//    - W valid 3 cycles before AW -> w_ready pulses once; b_valid only after AW, +WR_LATENCY cycles.
//    - Memory is updated exactly once.
// 3. Byte strobe:
//    - Prior word 32'h1122_3344, write 32'hAABB_CCDD with strb=4'b0101 -> readback 32'h11BB_33DD.
// 4. Out of range:
//    - AR addr=32'h0000_1000 -> r_resp=2'b11, r_data=0.
//    - AW addr=32'h8800_0000 -> b_resp=2'b11, no pmem_write.
// 5. Backpressure:
//    - RD_LATENCY=4, r_ready low for 5 cycles -> r_valid high at AR+4 and held; r_data stable; ar_ready low until the handshake.
// 6. Reset mid-read:
//    - Assert reset during R_WAIT -> outputs 0 immediately, no pmem_read call.
//    - After release, a new read completes normally.

Source files
------------

// File: rtl/axi_lite_dpic_sram_lat_if.sv
// axi_lite_dpic_sram_lat_if: AXI4-Lite bundle between the core fabric (master) and the simulation SRAM (slave).
interface axi_lite_dpic_sram_lat_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;
  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    b_valid;
  logic                    b_ready;
  logic [1:0]              b_resp;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;
  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  modport master (
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
    output ar_valid, ar_addr, ar_prot, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
  modport slave (
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
    input  ar_valid, ar_addr, ar_prot, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi_lite_dpic_sram_lat.sv
// axi_lite_dpic_sram_lat: AXI4-Lite simulation SRAM with independent AW/W, programmable latency and DECERR outside the window.
// Define AXI_SRAM_RAND_DELAY_EN to add 0..7 LFSR-driven wait cycles to every transaction.
module axi_lite_dpic_sram_lat #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    RD_LATENCY = 1,
  parameter int                    WR_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] MEM_BYTES  = 32'h0800_0000
) (
  input logic                     clock,
  input logic                     reset,
  axi_lite_dpic_sram_lat_if.slave ioAXI
);
  localparam int SB = DATA_WIDTH / 8;
  localparam int LANES = DATA_WIDTH / 32;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(SB - 1);
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  w_state_e              r_w_state, w_w_next;
  r_state_e              r_r_state, w_r_next;
  logic                  r_aw_ready, r_w_ready, r_b_valid, r_ar_ready, r_r_valid;
  logic [1:0]            r_b_resp, r_r_resp;
  logic [DATA_WIDTH-1:0] r_r_data, r_w_data;
  logic [SB-1:0]         r_w_strb;
  logic [ADDR_WIDTH-1:0] r_aw_addr, r_ar_addr;
  logic                  r_aw_held, r_wd_held, w_aw_held, w_wd_held;
  logic [4:0]            r_w_cnt, r_r_cnt, w_extra;
  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_w_commit, w_r_commit;
  logic                  w_unused;
  // Word store standing in for the DPI-C pmem model; unwritten words read as zero.
  logic [31:0] r_mem [logic [31:0]];
  function automatic logic [31:0] pmem_read(input logic [31:0] a);
    return r_mem.exists(a) ? r_mem[a] : 32'h0;
  endfunction
  function automatic void pmem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] v;
    v = pmem_read(a);
    for (int i = 0; i < 4; i++) if (m[i]) v[8*i+:8] = d[8*i+:8];
    r_mem[a] = v;
  endfunction
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return a >= BASE_ADDR && (a - BASE_ADDR) < MEM_BYTES;
  endfunction
  assign ioAXI.aw_ready = r_aw_ready;
  assign ioAXI.w_ready  = r_w_ready;
  assign ioAXI.b_valid  = r_b_valid;
  assign ioAXI.b_resp   = r_b_resp;
  assign ioAXI.ar_ready = r_ar_ready;
  assign ioAXI.r_valid  = r_r_valid;
  assign ioAXI.r_data   = r_r_data;
  assign ioAXI.r_resp   = r_r_resp;
  assign w_unused = ^{ioAXI.aw_prot, ioAXI.ar_prot};
  assign w_aw_hs = ioAXI.aw_valid && r_aw_ready;
  assign w_w_hs  = ioAXI.w_valid && r_w_ready;
  assign w_ar_hs = ioAXI.ar_valid && r_ar_ready;
  assign w_w_commit = r_w_state == W_WAIT && r_w_cnt == 5'd0;
  assign w_r_commit = r_r_state == R_WAIT && r_r_cnt == 5'd0;
`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_lfsr <= 16'hACE1;
    else r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_extra = {2'b00, r_lfsr[2:0]};
`else
  assign w_extra = 5'd0;
`endif
  // Held flags accumulate AW and W independently and clear only when the B handshake closes the write.
  always_comb begin
    w_aw_held = r_aw_held | w_aw_hs;
    w_wd_held = r_wd_held | w_w_hs;
    w_w_next = r_w_state;
    if (r_w_state == W_IDLE && w_aw_held && w_wd_held) w_w_next = W_WAIT;
    else if (w_w_commit) w_w_next = W_RESP;
    else if (r_w_state == W_RESP && ioAXI.b_ready) begin
      w_w_next = W_IDLE;
      w_aw_held = 1'b0;
      w_wd_held = 1'b0;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_w_state  <= W_IDLE;
      r_aw_held  <= 1'b0;
      r_wd_held  <= 1'b0;
      r_aw_ready <= 1'b0;
      r_w_ready  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_aw_addr  <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_w_cnt    <= 5'd0;
    end else begin
      r_w_state  <= w_w_next;
      r_aw_held  <= w_aw_held;
      r_wd_held  <= w_wd_held;
      r_aw_ready <= !w_aw_held;
      r_w_ready  <= !w_wd_held;
      r_b_valid  <= w_w_next == W_RESP;
      if (w_aw_hs) r_aw_addr <= ioAXI.aw_addr & ALIGN_MASK;
      if (w_w_hs) begin
        r_w_data <= ioAXI.w_data;
        r_w_strb <= ioAXI.w_strb;
      end
      r_w_cnt <= (r_w_state == W_IDLE && w_w_next == W_WAIT) ? 5'(WR_LATENCY - 1) + w_extra
               : r_w_cnt - {4'd0, r_w_cnt != 5'd0};
    end
  end
  always_comb begin
    w_r_next = r_r_state;
    if (r_r_state == R_IDLE && w_ar_hs) w_r_next = R_WAIT;
    else if (w_r_commit) w_r_next = R_RESP;
    else if (r_r_state == R_RESP && ioAXI.r_ready) w_r_next = R_IDLE;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_r_state  <= R_IDLE;
      r_ar_ready <= 1'b0;
      r_r_valid  <= 1'b0;
      r_ar_addr  <= '0;
      r_r_cnt    <= 5'd0;
    end else begin
      r_r_state  <= w_r_next;
      r_ar_ready <= w_r_next == R_IDLE;
      r_r_valid  <= w_r_next == R_RESP;
      if (w_ar_hs) r_ar_addr <= ioAXI.ar_addr & ALIGN_MASK;
      r_r_cnt <= (r_r_state == R_IDLE && w_r_next == R_WAIT) ? 5'(RD_LATENCY - 1) + w_extra
               : r_r_cnt - {4'd0, r_r_cnt != 5'd0};
    end
  end
  // Write is issued before the read sample so a same-edge read of the same word sees the new data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_b_resp <= OKAY;
      r_r_resp <= OKAY;
      r_r_data <= '0;
    end else begin
      if (w_w_commit) begin
        r_b_resp <= in_range(r_aw_addr) ? OKAY : DECERR;
        for (int l = 0; l < LANES; l++)
          if (in_range(r_aw_addr) && |r_w_strb[4*l+:4])
            pmem_write(32'(r_aw_addr) + 32'(4 * l), r_w_data[32*l+:32], r_w_strb[4*l+:4]);
      end
      if (w_r_commit) begin
        r_r_resp <= in_range(r_ar_addr) ? OKAY : DECERR;
        for (int l = 0; l < LANES; l++)
          r_r_data[32*l+:32] <= in_range(r_ar_addr) ? pmem_read(32'(r_ar_addr) + 32'(4 * l)) : 32'h0;
      end
    end
  end
endmodule
